// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter
// Double or triple buffered frame store between one pixel writer and several
// pixel readers. Frame swaps are synchronised to the display vsync. Read
// requests go through a fixed-priority arbiter (index 0 highest) onto a single
// BRAM read port. Read data is pipelined and tagged with the reader it belongs to.
// Optional feature: define FB_CLEAR_EN to zero every new write buffer after a swap.
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif

module frame_buffer_arbiter #(
  parameter int WIDTH        = 4,
  parameter int ADDR_LEN     = `ADDR_BITS,
  parameter int NUM_BUFS     = 2,
  parameter int NUM_READERS  = 2,
  parameter int READ_LATENCY = 2
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic                            swap_in,
  input  logic                            vsync_in,
  input  logic                            write_enable_in,
  input  logic [ADDR_LEN-1:0]             write_addr_in,
  input  logic [WIDTH-1:0]                write_data_in,
  output logic                            write_ready_out,
  input  logic [NUM_READERS-1:0]          read_req_in,
  input  logic [NUM_READERS*ADDR_LEN-1:0] read_addr_in,
  output logic [NUM_READERS-1:0]          read_grant_out,
  output logic [NUM_READERS-1:0]          read_valid_out,
  output logic [WIDTH-1:0]                read_data_out,
  output logic [1:0]                      display_idx_out,
  output logic [15:0]                     frames_dropped_out
);

  localparam int DEPTH   = 1 << ADDR_LEN;
  localparam int BUF_SEL = (NUM_BUFS > 2) ? 2 : 1;

  localparam logic [BUF_SEL-1:0] W_RST = '0;
  localparam logic [BUF_SEL-1:0] D_RST = BUF_SEL'(1);
  localparam logic [BUF_SEL-1:0] R_RST = BUF_SEL'(NUM_BUFS - 1);

  generate
    if (NUM_BUFS != 2 && NUM_BUFS != 3) begin : g_bad_num_bufs
      $error("frame_buffer_arbiter: NUM_BUFS must be 2 or 3");
    end
    if (READ_LATENCY < 1) begin : g_bad_latency
      $error("frame_buffer_arbiter: READ_LATENCY must be at least 1");
    end
  endgenerate

  // Buffer roles: write, display and (triple buffering only) ready.
  logic [BUF_SEL-1:0] w_idx, d_idx, r_idx;
  logic [BUF_SEL-1:0] w_next, d_next, r_next;
  logic               pending, pend_next;
  logic               drop_inc;
  logic [15:0]        dropped;
  logic               clearing;

  // Frame store and its single write port.
  logic [WIDTH-1:0]    mem [NUM_BUFS][DEPTH];
  logic                mem_we;
  logic [ADDR_LEN-1:0] mem_addr;
  logic [WIDTH-1:0]    mem_wdata;

  // Arbiter result.
  logic [NUM_READERS-1:0] grant;
  logic [ADDR_LEN-1:0]    sel_addr;

  // Read return pipeline; stage 0 is the BRAM output register.
  logic [NUM_READERS-1:0] valid_pipe [READ_LATENCY];
  logic [WIDTH-1:0]       data_pipe  [READ_LATENCY];

  // Swap/vsync handling: the swap is applied first, then vsync acts on the resulting pending flag
  always_comb begin
    w_next    = w_idx;
    d_next    = d_idx;
    r_next    = r_idx;
    pend_next = pending;
    drop_inc  = 1'b0;
    if (NUM_BUFS == 2) begin
      if (swap_in) begin
        if (pending || clearing) begin
          drop_inc = 1'b1;
        end else begin
          pend_next = 1'b1;
        end
      end
      if (vsync_in && pend_next) begin
        w_next    = d_idx;
        d_next    = w_idx;
        pend_next = 1'b0;
      end
    end else begin
      if (swap_in) begin
        if (clearing) begin
          drop_inc = 1'b1;
        end else begin
          if (pending) begin
            drop_inc = 1'b1;
          end
          w_next    = r_idx;
          r_next    = w_idx;
          pend_next = 1'b1;
        end
      end
      if (vsync_in && pend_next) begin
        d_next    = r_next;
        r_next    = d_idx;
        pend_next = 1'b0;
      end
    end
  end

  // Buffer role registers, pending flag and saturating drop counter
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      w_idx   <= W_RST;
      d_idx   <= D_RST;
      r_idx   <= R_RST;
      pending <= 1'b0;
      dropped <= '0;
    end else begin
      w_idx   <= w_next;
      d_idx   <= d_next;
      r_idx   <= r_next;
      pending <= pend_next;
      if (drop_inc && dropped != 16'hFFFF) begin
        dropped <= dropped + 16'd1;
      end
    end
  end

`ifdef FB_CLEAR_EN
  typedef enum logic {CLR_IDLE, CLR_BUSY} clr_state_t;

  clr_state_t          clr_state, clr_state_next;
  logic [ADDR_LEN-1:0] clr_addr, clr_addr_next;

  // Clear engine state register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      clr_state <= CLR_IDLE;
      clr_addr  <= '0;
    end else begin
      clr_state <= clr_state_next;
      clr_addr  <= clr_addr_next;
    end
  end

  // Start a sweep whenever the write buffer changes, then zero one address per cycle
  always_comb begin
    clr_state_next = clr_state;
    clr_addr_next  = clr_addr;
    case (clr_state)
      CLR_IDLE: begin
        if (w_next != w_idx) begin
          clr_state_next = CLR_BUSY;
          clr_addr_next  = '0;
        end
      end
      CLR_BUSY: begin
        if (clr_addr == '1) begin
          clr_state_next = CLR_IDLE;
        end
        clr_addr_next = clr_addr + ADDR_LEN'(1);
      end
    endcase
  end

  assign clearing  = (clr_state == CLR_BUSY);
  assign mem_addr  = clearing ? clr_addr : write_addr_in;
  assign mem_wdata = clearing ? '0 : write_data_in;
`else
  assign clearing  = 1'b0;
  assign mem_addr  = write_addr_in;
  assign mem_wdata = write_data_in;
`endif

  // The double buffer blocks the writer while a finished frame waits for vsync.
  assign write_ready_out = ~clearing & ~(pending & (NUM_BUFS == 2));
  assign mem_we          = clearing | (write_enable_in & write_ready_out);

  // Single write port into the current write buffer (writer or clear engine)
  always_ff @(posedge clk_in) begin
    if (mem_we) begin
      mem[w_idx][mem_addr] <= mem_wdata;
    end
  end

  // Fixed priority arbiter: scan from the top so the lowest asserted index wins
  always_comb begin
    grant    = '0;
    sel_addr = read_addr_in[ADDR_LEN-1:0];
    for (int i = NUM_READERS - 1; i >= 0; i--) begin
      if (read_req_in[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        sel_addr = read_addr_in[i*ADDR_LEN +: ADDR_LEN];
      end
    end
  end

  // Read pipeline: BRAM read from the display buffer seen at grant time, then delay stages
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        valid_pipe[i] <= '0;
        data_pipe[i]  <= '0;
      end
    end else begin
      valid_pipe[0] <= grant;
      data_pipe[0]  <= (|grant) ? mem[d_idx][sel_addr] : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        valid_pipe[i] <= valid_pipe[i-1];
        data_pipe[i]  <= data_pipe[i-1];
      end
    end
  end

  assign read_grant_out     = grant;
  assign read_valid_out     = valid_pipe[READ_LATENCY-1];
  assign read_data_out      = data_pipe[READ_LATENCY-1];
  assign display_idx_out    = 2'(d_idx);
  assign frames_dropped_out = dropped;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// tb_frame_buffer_arbiter
// Directed bench for frame_buffer_arbiter: one double-buffered and one
// triple-buffered instance share the clock, reset, write and read inputs.
// Follows FB_CLEAR_EN when it is defined.
module tb_frame_buffer_arbiter;

  localparam bit CLEAR = `ifdef FB_CLEAR_EN 1'b1 `else 1'b0 `endif ;

  localparam logic [1:0] ARB_REQ [8] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00};
  localparam logic [1:0] ARB_GNT [8] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       write_enable = 1'b0;
  logic [3:0] write_addr = '0;
  logic [3:0] write_data = '0;
  logic [1:0] read_req = '0;
  logic [7:0] read_addr = '0;

  logic       swap2 = 1'b0, vsync2 = 1'b0;
  logic       swap3 = 1'b0, vsync3 = 1'b0;

  logic       wr2, wr3;
  logic [1:0] grant2, grant3, valid2, valid3, disp2, disp3;
  logic [3:0] data2, data3;
  logic [15:0] drop2, drop3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  frame_buffer_arbiter #(
    .WIDTH(4), .ADDR_LEN(4), .NUM_BUFS(2), .NUM_READERS(2), .READ_LATENCY(2)
  ) dut2 (
    .clk_in(clk), .rst_n_in(rst_n), .swap_in(swap2), .vsync_in(vsync2),
    .write_enable_in(write_enable), .write_addr_in(write_addr), .write_data_in(write_data),
    .write_ready_out(wr2), .read_req_in(read_req), .read_addr_in(read_addr),
    .read_grant_out(grant2), .read_valid_out(valid2), .read_data_out(data2),
    .display_idx_out(disp2), .frames_dropped_out(drop2)
  );

  frame_buffer_arbiter #(
    .WIDTH(4), .ADDR_LEN(4), .NUM_BUFS(3), .NUM_READERS(2), .READ_LATENCY(2)
  ) dut3 (
    .clk_in(clk), .rst_n_in(rst_n), .swap_in(swap3), .vsync_in(vsync3),
    .write_enable_in(write_enable), .write_addr_in(write_addr), .write_data_in(write_data),
    .write_ready_out(wr3), .read_req_in(read_req), .read_addr_in(read_addr),
    .read_grant_out(grant3), .read_valid_out(valid3), .read_data_out(data3),
    .display_idx_out(disp3), .frames_dropped_out(drop3)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready2;
    int c = 0;
    while (wr2 !== 1'b1 && c < 40) begin
      tick();
      c++;
    end
    n_checks++;
    if (wr2 !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL wait_ready2: write_ready_out=%b required 1 within 40 cycles", wr2);
    end
  endtask

  task automatic wait_ready3;
    int c = 0;
    while (wr3 !== 1'b1 && c < 40) begin
      tick();
      c++;
    end
    n_checks++;
    if (wr3 !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL wait_ready3: write_ready_out=%b required 1 within 40 cycles", wr3);
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (wr2 !== 1'b1)     begin n_fail++; $display("[TB] FAIL reset_ready2: got %b required 1", wr2); end
    n_checks++; if (valid2 !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_valid2: got %b required 00", valid2); end
    n_checks++; if (data2 !== 4'h0)   begin n_fail++; $display("[TB] FAIL reset_data2: got %h required 0", data2); end
    n_checks++; if (disp2 !== 2'd1)   begin n_fail++; $display("[TB] FAIL reset_disp2: got %0d required 1", disp2); end
    n_checks++; if (drop2 !== 16'd0)  begin n_fail++; $display("[TB] FAIL reset_drop2: got %0d required 0", drop2); end
    n_checks++; if (disp3 !== 2'd1)   begin n_fail++; $display("[TB] FAIL reset_disp3: got %0d required 1", disp3); end
    n_checks++; if (wr3 !== 1'b1)     begin n_fail++; $display("[TB] FAIL reset_ready3: got %b required 1", wr3); end
    n_checks++; if (data3 !== 4'h0)   begin n_fail++; $display("[TB] FAIL reset_data3: got %h required 0", data3); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_double_swap;
    write_enable = 1'b1; write_addr = 4'd5; write_data = 4'hA;
    tick();
    write_addr = 4'd6; write_data = 4'h6;
    tick();
    write_enable = 1'b0;
    n_checks++; if (wr2 !== 1'b1) begin n_fail++; $display("[TB] FAIL dswap_ready_before: got %b required 1", wr2); end
    swap2 = 1'b1;
    tick();
    swap2 = 1'b0;
    n_checks++; if (wr2 !== 1'b0) begin n_fail++; $display("[TB] FAIL dswap_ready_pending: got %b required 0", wr2); end
    for (int k = 1; k <= 9; k++) begin
      write_enable = (k == 3);
      write_addr   = 4'd5;
      write_data   = 4'h3;
      tick();
      n_checks++; if (wr2 !== 1'b0) begin n_fail++; $display("[TB] FAIL dswap_ready_wait%0d: got %b required 0", k, wr2); end
    end
    write_enable = 1'b0;
    vsync2 = 1'b1;
    tick();
    vsync2 = 1'b0;
    n_checks++; if (disp2 !== 2'd0) begin n_fail++; $display("[TB] FAIL dswap_disp: got %0d required 0", disp2); end
    n_checks++; if (drop2 !== 16'd0) begin n_fail++; $display("[TB] FAIL dswap_drop: got %0d required 0", drop2); end
    n_checks++; if (wr2 !== !CLEAR) begin n_fail++; $display("[TB] FAIL dswap_ready_after: got %b required %b", wr2, !CLEAR); end
    read_req = 2'b01; read_addr = {4'd0, 4'd5};
    #1;
    n_checks++; if (grant2 !== 2'b01) begin n_fail++; $display("[TB] FAIL dswap_grant: got %b required 01", grant2); end
    tick();
    read_req = 2'b00;
    n_checks++; if (valid2 !== 2'b00) begin n_fail++; $display("[TB] FAIL dswap_valid_early: got %b required 00", valid2); end
    tick();
    n_checks++; if (valid2 !== 2'b01) begin n_fail++; $display("[TB] FAIL dswap_valid: got %b required 01", valid2); end
    n_checks++; if (data2 !== 4'hA)   begin n_fail++; $display("[TB] FAIL dswap_data: got %h required a", data2); end
    tick();
    n_checks++; if (valid2 !== 2'b00) begin n_fail++; $display("[TB] FAIL dswap_valid_late: got %b required 00", valid2); end
    n_checks++; if (data2 !== 4'h0)   begin n_fail++; $display("[TB] FAIL dswap_data_late: got %h required 0", data2); end
  endtask

  task automatic test_arbitration;
    logic [1:0] exp_v;
    logic [3:0] exp_d;
    read_addr = {4'd6, 4'd5};
    for (int i = 0; i < 8; i++) begin
      exp_v = 2'b00;
      if (i >= 2) exp_v = ARB_GNT[i-2];
      exp_d = (exp_v == 2'b01) ? 4'hA : (exp_v == 2'b10) ? 4'h6 : 4'h0;
      n_checks++; if (valid2 !== exp_v) begin n_fail++; $display("[TB] FAIL arb_valid%0d: got %b required %b", i, valid2, exp_v); end
      n_checks++; if (data2 !== exp_d)  begin n_fail++; $display("[TB] FAIL arb_data%0d: got %h required %h", i, data2, exp_d); end
      read_req = ARB_REQ[i];
      #1;
      n_checks++; if (grant2 !== ARB_GNT[i]) begin n_fail++; $display("[TB] FAIL arb_grant%0d: got %b required %b", i, grant2, ARB_GNT[i]); end
      n_checks++; if (grant3 !== ARB_GNT[i]) begin n_fail++; $display("[TB] FAIL arb_grant3_%0d: got %b required %b", i, grant3, ARB_GNT[i]); end
      tick();
    end
    n_checks++; if (valid3 !== 2'b00) begin n_fail++; $display("[TB] FAIL arb_valid3_idle: got %b required 00", valid3); end
  endtask

  task automatic test_double_drop;
    wait_ready2();
    swap2 = 1'b1;
    tick();
    n_checks++; if (wr2 !== 1'b0)    begin n_fail++; $display("[TB] FAIL ddrop_ready1: got %b required 0", wr2); end
    n_checks++; if (drop2 !== 16'd0) begin n_fail++; $display("[TB] FAIL ddrop_count1: got %0d required 0", drop2); end
    tick();
    swap2 = 1'b0;
    n_checks++; if (wr2 !== 1'b0)    begin n_fail++; $display("[TB] FAIL ddrop_ready2: got %b required 0", wr2); end
    n_checks++; if (drop2 !== 16'd1) begin n_fail++; $display("[TB] FAIL ddrop_count2: got %0d required 1", drop2); end
    vsync2 = 1'b1;
    tick();
    vsync2 = 1'b0;
    n_checks++; if (disp2 !== 2'd1)  begin n_fail++; $display("[TB] FAIL ddrop_disp: got %0d required 1", disp2); end
    n_checks++; if (drop2 !== 16'd1) begin n_fail++; $display("[TB] FAIL ddrop_count3: got %0d required 1", drop2); end
    n_checks++; if (wr2 !== !CLEAR)  begin n_fail++; $display("[TB] FAIL ddrop_ready3: got %b required %b", wr2, !CLEAR); end
  endtask

  task automatic test_simultaneous;
    wait_ready2();
    swap2 = 1'b1; vsync2 = 1'b1;
    #1;
    n_checks++; if (disp2 !== 2'd1) begin n_fail++; $display("[TB] FAIL sim_disp_before: got %0d required 1", disp2); end
    tick();
    swap2 = 1'b0; vsync2 = 1'b0;
    n_checks++; if (disp2 !== 2'd0)  begin n_fail++; $display("[TB] FAIL sim_disp_after: got %0d required 0", disp2); end
    n_checks++; if (drop2 !== 16'd1) begin n_fail++; $display("[TB] FAIL sim_drop: got %0d required 1", drop2); end
    n_checks++; if (wr2 !== !CLEAR)  begin n_fail++; $display("[TB] FAIL sim_ready: got %b required %b", wr2, !CLEAR); end
  endtask

`ifdef FB_CLEAR_EN
  task automatic test_clear;
    logic [1:0] exp_v;
    wait_ready2();
    swap2 = 1'b1; vsync2 = 1'b1;
    tick();
    swap2 = 1'b0; vsync2 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (wr2 !== 1'b0) begin n_fail++; $display("[TB] FAIL clear_busy%0d: got %b required 0", i, wr2); end
      tick();
    end
    n_checks++; if (wr2 !== 1'b1) begin n_fail++; $display("[TB] FAIL clear_done: got %b required 1", wr2); end
    swap2 = 1'b1; vsync2 = 1'b1;
    tick();
    swap2 = 1'b0; vsync2 = 1'b0;
    n_checks++; if (disp2 !== 2'd0) begin n_fail++; $display("[TB] FAIL clear_disp: got %0d required 0", disp2); end
    for (int i = 0; i < 18; i++) begin
      exp_v = (i >= 2) ? 2'b01 : 2'b00;
      n_checks++; if (valid2 !== exp_v) begin n_fail++; $display("[TB] FAIL clear_valid%0d: got %b required %b", i, valid2, exp_v); end
      n_checks++; if (data2 !== 4'h0)   begin n_fail++; $display("[TB] FAIL clear_data%0d: got %h required 0", i, data2); end
      read_req  = (i < 16) ? 2'b01 : 2'b00;
      read_addr = {4'd0, 4'(i)};
      tick();
    end
    wait_ready2();
  endtask
`endif

  task automatic test_triple;
    logic [1:0] exp_disp;
    swap3 = 1'b1;
    tick();
    n_checks++; if (disp3 !== 2'd1)  begin n_fail++; $display("[TB] FAIL tri_disp1: got %0d required 1", disp3); end
    n_checks++; if (drop3 !== 16'd0) begin n_fail++; $display("[TB] FAIL tri_drop1: got %0d required 0", drop3); end
    n_checks++; if (wr3 !== !CLEAR)  begin n_fail++; $display("[TB] FAIL tri_ready1: got %b required %b", wr3, !CLEAR); end
    tick();
    swap3 = 1'b0;
    n_checks++; if (drop3 !== 16'd1) begin n_fail++; $display("[TB] FAIL tri_drop2: got %0d required 1", drop3); end
    n_checks++; if (wr3 !== !CLEAR)  begin n_fail++; $display("[TB] FAIL tri_ready2: got %b required %b", wr3, !CLEAR); end
    vsync3 = 1'b1;
    tick();
    exp_disp = CLEAR ? 2'd0 : 2'd2;
    n_checks++; if (disp3 !== exp_disp) begin n_fail++; $display("[TB] FAIL tri_disp3: got %0d required %0d", disp3, exp_disp); end
    tick();
    vsync3 = 1'b0;
    n_checks++; if (disp3 !== exp_disp) begin n_fail++; $display("[TB] FAIL tri_disp_nopend: got %0d required %0d", disp3, exp_disp); end
    n_checks++; if (drop3 !== 16'd1)    begin n_fail++; $display("[TB] FAIL tri_drop3: got %0d required 1", drop3); end
    wait_ready3();
    swap3 = 1'b1; vsync3 = 1'b1;
    #1;
    n_checks++; if (disp3 !== exp_disp) begin n_fail++; $display("[TB] FAIL tri_sim_before: got %0d required %0d", disp3, exp_disp); end
    tick();
    swap3 = 1'b0; vsync3 = 1'b0;
    exp_disp = CLEAR ? 2'd2 : 2'd0;
    n_checks++; if (disp3 !== exp_disp) begin n_fail++; $display("[TB] FAIL tri_sim_after: got %0d required %0d", disp3, exp_disp); end
    n_checks++; if (drop3 !== 16'd1)    begin n_fail++; $display("[TB] FAIL tri_sim_drop: got %0d required 1", drop3); end
  endtask

  task automatic test_reset_midframe;
    read_req = 2'b01; read_addr = {4'd0, 4'd5};
    tick();
    rst_n = 1'b0;
    read_req = 2'b00;
    #1;
    n_checks++; if (valid2 !== 2'b00) begin n_fail++; $display("[TB] FAIL mreset_valid2: got %b required 00", valid2); end
    n_checks++; if (data2 !== 4'h0)   begin n_fail++; $display("[TB] FAIL mreset_data2: got %h required 0", data2); end
    n_checks++; if (disp2 !== 2'd1)   begin n_fail++; $display("[TB] FAIL mreset_disp2: got %0d required 1", disp2); end
    n_checks++; if (drop2 !== 16'd0)  begin n_fail++; $display("[TB] FAIL mreset_drop2: got %0d required 0", drop2); end
    n_checks++; if (wr2 !== 1'b1)     begin n_fail++; $display("[TB] FAIL mreset_ready2: got %b required 1", wr2); end
    n_checks++; if (disp3 !== 2'd1)   begin n_fail++; $display("[TB] FAIL mreset_disp3: got %0d required 1", disp3); end
    n_checks++; if (drop3 !== 16'd0)  begin n_fail++; $display("[TB] FAIL mreset_drop3: got %0d required 0", drop3); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (valid2 !== 2'b00) begin n_fail++; $display("[TB] FAIL mreset_flush%0d: got %b required 00", i, valid2); end
    end
  endtask

  initial begin
    test_reset();
    test_double_swap();
    test_arbitration();
    test_double_drop();
    test_simultaneous();
`ifdef FB_CLEAR_EN
    test_clear();
`endif
    test_triple();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
